// File: rtl/scsp_dma_ctrl.sv
// SCSP DMA sequencer: copies words between sound RAM and the internal register
// space one read/write pair at a time, then pulses the DMA-end interrupt event.
module scsp_dma_ctrl #(
    parameter int unsigned MEM_AW = 19,
    parameter int unsigned REG_AW = 11
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [MEM_AW-1:0] DMEA,
    input  logic [REG_AW-1:0] DRGA,
    input  logic [10:0]       DTLG,
    input  logic              DDIR,
    input  logic              DGATE,
    input  logic              DEXE_SET,
    output logic              BUSY,
    output logic              DONE_IRQ,
    output logic [MEM_AW-1:0] MEM_A,
    output logic [15:0]       MEM_DO,
    input  logic [15:0]       MEM_DI,
    output logic              MEM_RD,
    output logic              MEM_WR,
    input  logic              MEM_RDY,
    output logic [REG_AW-1:0] REG_A,
    output logic [15:0]       REG_DO,
    input  logic [15:0]       REG_DI,
    output logic              REG_RD,
    output logic              REG_WR,
    input  logic              REG_RDY
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [MEM_AW-1:0] mem_ptr, mem_ptr_nxt;
    logic [REG_AW-1:0] reg_ptr, reg_ptr_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              dir, dir_nxt;
    logic              gate, gate_nxt;
    logic [DW-1:0]     data, data_nxt;

    logic              busy_nxt, done_nxt;
    logic [MEM_AW-1:0] mem_a_nxt;
    logic [DW-1:0]     mem_do_nxt;
    logic              mem_rd_nxt, mem_wr_nxt;
    logic [REG_AW-1:0] reg_a_nxt;
    logic [DW-1:0]     reg_do_nxt;
    logic              reg_rd_nxt, reg_wr_nxt;

    logic              issue_rd, issue_wr, finish;
    logic [DW-1:0]     wdata;
    logic              src_rdy, dst_rdy;

    // Only the acknowledge of the port that owns the pending request matters.
    assign src_rdy = dir ? REG_RDY : MEM_RDY;
    assign dst_rdy = dir ? MEM_RDY : REG_RDY;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        mem_ptr_nxt = mem_ptr;
        reg_ptr_nxt = reg_ptr;
        cnt_nxt     = cnt;
        dir_nxt     = dir;
        gate_nxt    = gate;
        data_nxt    = data;
        busy_nxt    = BUSY;
        done_nxt    = 1'b0;
        mem_a_nxt   = MEM_A;
        mem_do_nxt  = MEM_DO;
        mem_rd_nxt  = MEM_RD;
        mem_wr_nxt  = MEM_WR;
        reg_a_nxt   = REG_A;
        reg_do_nxt  = REG_DO;
        reg_rd_nxt  = REG_RD;
        reg_wr_nxt  = REG_WR;
        issue_rd    = 1'b0;
        issue_wr    = 1'b0;
        finish      = 1'b0;
        wdata       = '0;

        case (state)
            S_IDLE: begin
                // BUSY in IDLE marks the launch cycle after the parameters were latched.
                if (BUSY) begin
                    if (cnt == '0) begin
                        finish = 1'b1;
                    end else if (gate) begin
                        issue_wr = 1'b1;
                    end else begin
                        issue_rd = 1'b1;
                    end
                end else if (DEXE_SET) begin
                    mem_ptr_nxt = DMEA;
                    reg_ptr_nxt = DRGA;
                    cnt_nxt     = DTLG;
                    dir_nxt     = DDIR;
                    gate_nxt    = DGATE;
                    busy_nxt    = 1'b1;
                end
            end
            S_RD: begin
                if (src_rdy) begin
                    data_nxt   = dir ? REG_DI : MEM_DI;
                    mem_rd_nxt = 1'b0;
                    reg_rd_nxt = 1'b0;
                    issue_wr   = 1'b1;
                end
            end
            S_WR: begin
                if (dst_rdy) begin
                    mem_wr_nxt  = 1'b0;
                    reg_wr_nxt  = 1'b0;
                    mem_ptr_nxt = mem_ptr + MEM_AW'(1);
                    reg_ptr_nxt = reg_ptr + REG_AW'(1);
                    cnt_nxt     = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        finish = 1'b1;
                    end else if (gate) begin
                        issue_wr = 1'b1;
                    end else begin
                        issue_rd = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (finish) begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
        end

        if (issue_rd) begin
            state_nxt = S_RD;
            if (dir) begin
                reg_rd_nxt = 1'b1;
                reg_a_nxt  = reg_ptr_nxt;
            end else begin
                mem_rd_nxt = 1'b1;
                mem_a_nxt  = mem_ptr_nxt;
            end
        end

        // Write data comes from the latch as updated this cycle, so a read
        // acknowledged now feeds the write raised on the same edge.
        if (issue_wr) begin
            state_nxt = S_WR;
            wdata     = gate ? '0 : data_nxt;
            if (dir) begin
                mem_wr_nxt = 1'b1;
                mem_a_nxt  = mem_ptr_nxt;
                mem_do_nxt = wdata;
            end else begin
                reg_wr_nxt = 1'b1;
                reg_a_nxt  = reg_ptr_nxt;
                reg_do_nxt = wdata;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            mem_ptr  <= '0;
            reg_ptr  <= '0;
            cnt      <= '0;
            dir      <= 1'b0;
            gate     <= 1'b0;
            data     <= '0;
            BUSY     <= 1'b0;
            DONE_IRQ <= 1'b0;
            MEM_A    <= '0;
            MEM_DO   <= '0;
            MEM_RD   <= 1'b0;
            MEM_WR   <= 1'b0;
            REG_A    <= '0;
            REG_DO   <= '0;
            REG_RD   <= 1'b0;
            REG_WR   <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_ptr  <= mem_ptr_nxt;
            reg_ptr  <= reg_ptr_nxt;
            cnt      <= cnt_nxt;
            dir      <= dir_nxt;
            gate     <= gate_nxt;
            data     <= data_nxt;
            BUSY     <= busy_nxt;
            DONE_IRQ <= done_nxt;
            MEM_A    <= mem_a_nxt;
            MEM_DO   <= mem_do_nxt;
            MEM_RD   <= mem_rd_nxt;
            MEM_WR   <= mem_wr_nxt;
            REG_A    <= reg_a_nxt;
            REG_DO   <= reg_do_nxt;
            REG_RD   <= reg_rd_nxt;
            REG_WR   <= reg_wr_nxt;
        end
    end

endmodule

// File: tb/tb_scsp_dma_ctrl.sv
// Bench for scsp_dma_ctrl: port responders with programmable wait states, a
// word-level transfer model feeding an expected-event queue, and a monitor.
module tb_scsp_dma_ctrl;

    localparam int unsigned MEM_AW = 19;
    localparam int unsigned REG_AW = 11;

    localparam logic [2:0] K_MRD  = 3'd0;
    localparam logic [2:0] K_MWR  = 3'd1;
    localparam logic [2:0] K_RRD  = 3'd2;
    localparam logic [2:0] K_RWR  = 3'd3;
    localparam logic [2:0] K_DONE = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [18:0] addr;
        logic [15:0] data;
    } ev_t;

    logic              CLK;
    logic              RST_N;
    logic [MEM_AW-1:0] DMEA;
    logic [REG_AW-1:0] DRGA;
    logic [10:0]       DTLG;
    logic              DDIR, DGATE, DEXE_SET;
    logic              BUSY, DONE_IRQ;
    logic [MEM_AW-1:0] MEM_A;
    logic [15:0]       MEM_DO, MEM_DI;
    logic              MEM_RD, MEM_WR, MEM_RDY;
    logic [REG_AW-1:0] REG_A;
    logic [15:0]       REG_DO, REG_DI;
    logic              REG_RD, REG_WR, REG_RDY;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] salt;
    logic [15:0] mem_pre [int];
    int          delay_mode = 0;
    bit          stray_en = 1'b1;

    scsp_dma_ctrl #(.MEM_AW(MEM_AW), .REG_AW(REG_AW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .DMEA(DMEA), .DRGA(DRGA), .DTLG(DTLG), .DDIR(DDIR), .DGATE(DGATE),
        .DEXE_SET(DEXE_SET), .BUSY(BUSY), .DONE_IRQ(DONE_IRQ),
        .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_DI(MEM_DI),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_RDY(MEM_RDY),
        .REG_A(REG_A), .REG_DO(REG_DO), .REG_DI(REG_DI),
        .REG_RD(REG_RD), .REG_WR(REG_WR), .REG_RDY(REG_RDY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] mem_val(input logic [18:0] a);
        if (mem_pre.exists(int'(a))) return mem_pre[int'(a)];
        return 16'(a[15:0] * 16'd40503) ^ {13'd0, a[18:16]} ^ salt;
    endfunction

    function automatic logic [15:0] reg_val(input logic [10:0] a);
        return 16'({5'd0, a} * 16'd7 + 16'hC001) ^ ~salt;
    endfunction

    function automatic int pick_delay();
        if (delay_mode < 4) return delay_mode;
        return int'($urandom_range(0, 3));
    endfunction

    function automatic ev_t ev(input logic [2:0] k, input logic [18:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic observe(input logic [2:0] k, input logic [18:0] a, input logic [15:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none", k, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.addr !== a || e.data !== d) begin
                errors++;
                $display("FAIL event: got kind %0d addr %0h data %0h, expected kind %0d addr %0h data %0h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Reference model: word i reads source[base+i] and writes dest[base+i], then one DMA-end event.
    task automatic push_model(input logic [18:0] mea, input logic [10:0] rga, input int len,
                              input logic dir, input logic gate);
        for (int i = 0; i < len; i++) begin
            logic [18:0] ma;
            logic [10:0] ra;
            logic [15:0] v;
            ma = mea + 19'(i);
            ra = rga + 11'(i);
            v  = dir ? reg_val(ra) : mem_val(ma);
            if (gate) v = 16'h0000;
            else exp_q.push_back(dir ? ev(K_RRD, {8'd0, ra}, 16'h0) : ev(K_MRD, ma, 16'h0));
            exp_q.push_back(dir ? ev(K_MWR, ma, v) : ev(K_RWR, {8'd0, ra}, v));
        end
        exp_q.push_back(ev(K_DONE, 19'h0, 16'h0));
    endtask

    // Port responders plus monitor; an access completes at the posedge after RDY is raised here.
    int         mcnt = 0, rcnt = 0, mdly = 0, rdly = 0, nreq;
    logic       mpend = 1'b0, rpend = 1'b0;
    logic [36:0] msave, rsave;
    always @(negedge CLK) begin
        if (!RST_N) begin
            MEM_RDY = 1'b0; REG_RDY = 1'b0; MEM_DI = 16'h0; REG_DI = 16'h0;
            mcnt = 0; rcnt = 0; mpend = 1'b0; rpend = 1'b0;
        end else begin
            nreq = int'(MEM_RD) + int'(MEM_WR) + int'(REG_RD) + int'(REG_WR);
            checks++;
            if (nreq > 1) begin
                errors++;
                $display("FAIL onehot: got %0d requests, expected at most 1", nreq);
            end
            if (mpend) check("mem_hold", {MEM_RD, MEM_WR, MEM_A, MEM_DO}, msave);
            if (rpend) check("reg_hold", {REG_RD, REG_WR, 8'd0, REG_A, REG_DO}, rsave);

            MEM_DI = mem_val(MEM_A);
            REG_DI = reg_val(REG_A);
            if (MEM_RD || MEM_WR) begin
                if (mcnt >= mdly) begin MEM_RDY = 1'b1; mcnt = 0; mdly = pick_delay(); end
                else begin MEM_RDY = 1'b0; mcnt++; end
            end else begin
                MEM_RDY = stray_en && ($urandom_range(0, 3) == 0);
                mcnt = 0; mdly = pick_delay();
            end
            if (REG_RD || REG_WR) begin
                if (rcnt >= rdly) begin REG_RDY = 1'b1; rcnt = 0; rdly = pick_delay(); end
                else begin REG_RDY = 1'b0; rcnt++; end
            end else begin
                REG_RDY = stray_en && ($urandom_range(0, 3) == 0);
                rcnt = 0; rdly = pick_delay();
            end
            mpend = (MEM_RD || MEM_WR) && !MEM_RDY;
            rpend = (REG_RD || REG_WR) && !REG_RDY;
            msave = {MEM_RD, MEM_WR, MEM_A, MEM_DO};
            rsave = {REG_RD, REG_WR, 8'd0, REG_A, REG_DO};

            if (MEM_RD && MEM_RDY) observe(K_MRD, MEM_A, 16'h0);
            if (MEM_WR && MEM_RDY) observe(K_MWR, MEM_A, MEM_DO);
            if (REG_RD && REG_RDY) observe(K_RRD, {8'd0, REG_A}, 16'h0);
            if (REG_WR && REG_RDY) observe(K_RWR, {8'd0, REG_A}, REG_DO);
            if (DONE_IRQ) begin
                observe(K_DONE, 19'h0, 16'h0);
                check("busy_at_done", BUSY, 0);
            end
        end
    end

    task automatic run_xfer(input logic [18:0] mea, input logic [10:0] rga, input int len,
                            input logic dir, input logic gate, input int dmode,
                            input bit chk_lat, input bit repulse);
        int busy_n, done_c, c, exp_done;
        delay_mode = dmode;
        push_model(mea, rga, len, dir, gate);
        @(negedge CLK);
        DMEA = mea; DRGA = rga; DTLG = 11'(len); DDIR = dir; DGATE = gate; DEXE_SET = 1'b1;
        @(negedge CLK);
        DEXE_SET = 1'b0;
        DMEA = 19'($urandom); DRGA = 11'($urandom); DTLG = 11'($urandom);
        DDIR = ~dir; DGATE = 1'($urandom);
        busy_n = 0; done_c = 0; c = 1;
        while (c <= 500 && done_c == 0) begin
            if (DONE_IRQ) done_c = c;
            else if (BUSY) busy_n++;
            if (repulse && c == 3) begin DEXE_SET = 1'b1; DTLG = 11'd5; end
            if (repulse && c == 4) DEXE_SET = 1'b0;
            if (done_c == 0) begin
                @(negedge CLK);
                c++;
            end
        end
        DEXE_SET = 1'b0;
        checks++;
        if (done_c == 0) begin
            errors++;
            $display("FAIL done_timeout: got no DONE_IRQ in %0d cycles, expected one", c - 1);
        end
        if (chk_lat) begin
            exp_done = gate ? len + 2 : 2 * len + 2;
            check("done_cycle", 64'(done_c), 64'(exp_done));
            check("busy_cycles", 64'(busy_n), 64'(exp_done - 1));
        end
        repeat (2) @(negedge CLK);
        check("xfer_drained", 64'(exp_q.size()), 0);
    endtask

    initial begin
        int c;
        logic [18:0] mea;
        logic [10:0] rga;
        RST_N = 1'b0; DEXE_SET = 1'b0;
        DMEA = '0; DRGA = '0; DTLG = '0; DDIR = 1'b0; DGATE = 1'b0;
        salt = 16'($urandom);
        mem_pre[32'h100] = 16'h1111;
        mem_pre[32'h101] = 16'h2222;
        mem_pre[32'h102] = 16'h3333;
        repeat (2) @(negedge CLK);
        check("reset_ctl", {BUSY, DONE_IRQ, MEM_RD, MEM_WR, REG_RD, REG_WR}, 0);
        check("reset_addr", {MEM_A, REG_A}, 0);
        check("reset_data", {MEM_DO, REG_DO}, 0);
        RST_N = 1'b1;

        run_xfer(19'h00100, 11'h200, 3, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        run_xfer(19'($urandom), 11'($urandom), 2, 1'b1, 1'b0, 3, 1'b0, 1'b0);
        run_xfer(19'h7FFFE, 11'($urandom), 4, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        run_xfer(19'($urandom), 11'($urandom), 0, 1'($urandom), 1'b0, 0, 1'b1, 1'b0);
        run_xfer(19'($urandom), 11'($urandom), 2, 1'b0, 1'b0, 0, 1'b1, 1'b1);

        // Reset while the second word's memory read is still waiting for RDY.
        delay_mode = 2;
        mea = 19'($urandom); rga = 11'($urandom);
        exp_q.push_back(ev(K_MRD, mea, 16'h0));
        exp_q.push_back(ev(K_RWR, {8'd0, rga}, mem_val(mea)));
        @(negedge CLK);
        DMEA = mea; DRGA = rga; DTLG = 11'd3; DDIR = 1'b0; DGATE = 1'b0; DEXE_SET = 1'b1;
        @(negedge CLK);
        DEXE_SET = 1'b0;
        c = 0;
        while (c < 200 && !(exp_q.size() == 0 && MEM_RD)) begin
            @(negedge CLK);
            c++;
        end
        checks++;
        if (c >= 200) begin
            errors++;
            $display("FAIL rd2_timeout: got no pending second read, expected one");
        end
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_ctl", {BUSY, DONE_IRQ, MEM_RD, MEM_WR, REG_RD, REG_WR}, 0);
        check("async_rst_addr", {MEM_A, REG_A}, 0);
        check("async_rst_data", {MEM_DO, REG_DO}, 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_rst_idle", {BUSY, DONE_IRQ, MEM_RD, MEM_WR, REG_RD, REG_WR}, 0);
        check("post_rst_queue", 64'(exp_q.size()), 0);
        run_xfer(19'($urandom), 11'($urandom), 3, 1'b0, 1'b0, 0, 1'b1, 1'b0);

        for (int t = 0; t < 30; t++) begin
            int len, dmode;
            logic dir, gate;
            mea   = ($urandom_range(0, 3) == 0) ? 19'h7FFF8 + 19'($urandom_range(0, 7)) : 19'($urandom);
            rga   = ($urandom_range(0, 3) == 0) ? 11'h7F8 + 11'($urandom_range(0, 7)) : 11'($urandom);
            len   = int'($urandom_range(0, 8));
            dir   = 1'($urandom);
            gate  = 1'($urandom);
            dmode = int'($urandom_range(0, 4));
            run_xfer(mea, rga, len, dir, gate, dmode, dmode == 0, 1'b0);
        end

        repeat (10) @(negedge CLK);
        check("final_queue", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/scsp_dma_ctrl.md
Name: scsp_dma_ctrl

Overview:
- Sequences SCSP DMA block transfers between sound RAM and the SCSP internal register/DSP space, programmed through control registers CR5–CR7 (DMEA, DRGA, DTLG, DDIR, DGATE, DEXE).
- Sits between the SCSP register file and two shared access ports: the sound-RAM arbiter and the internal register bus.
- Moves one 16-bit word per read/write pair, drops DEXE on completion and raises the DMA-end interrupt event (bit 4 of SCIPD/MCIPD).

Parameters:
- MEM_AW, 19, sound-RAM word-address width (byte address bits [19:1]).
- REG_AW, 11, register-space word-address width (byte address bits [11:1]).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- DMEA  in  MEM_AW  memory start word address, {DMEAH,DMEAL}
- DRGA  in  REG_AW  register start word address
- DTLG  in  11  transfer length in words
- DDIR  in  1  0 = memory→register, 1 = register→memory
- DGATE  in  1  1 = write zeros; skip the read phase
- DEXE_SET  in  1  one-cycle pulse when CPU writes DEXE=1
- BUSY  out  1  DEXE readback
- DONE_IRQ  out  1  one-cycle DMA-end event to the interrupt logic
- MEM_A  out  MEM_AW  memory word address
- MEM_DO  out  16  memory write data
- MEM_DI  in  16  memory read data
- MEM_RD / MEM_WR  out  1  memory read / write request
- MEM_RDY  in  1  memory access acknowledge
- REG_A  out  REG_AW  register word address
- REG_DO  out  16  register write data
- REG_DI  in  16  register read data
- REG_RD / REG_WR  out  1  register read / write request
- REG_RDY  in  1  register access acknowledge

Behaviour:
- Clocking and reset: one clock CLK. RST_N is asynchronous and active-low. Reset clears every output to 0 and returns the FSM to IDLE. The same applies when reset is asserted mid-transfer: the in-flight request drops immediately and no DONE_IRQ is generated.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - On DEXE_SET, latch DMEA, DRGA, DTLG, DDIR and DGATE into working counters.
  - Next cycle: BUSY=1. Go to WR if DGATE=1, otherwise RD. If the latched DTLG=0, go to DONE instead.
  - DEXE_SET while BUSY=1 is ignored. Register inputs may change during a transfer without effect.
- RD:
  - Assert the source-port read request: MEM_RD if DDIR=0, REG_RD if DDIR=1.
  - Hold the request with a stable address until the matching RDY is sampled high.
  - In that cycle, capture DI into the data latch and go to WR; the request deasserts next cycle.
- WR:
  - Assert the destination write request (REG_WR if DDIR=0, MEM_WR if DDIR=1).
  - Drive DO from the data latch, or 16'h0000 when DGATE=1.
  - When the matching RDY is sampled high: increment both addresses by 1 and decrement the remaining count.
  - If the remaining count becomes 0, go to DONE; otherwise go to RD (or back to WR if DGATE=1).
- DONE: for one cycle, DONE_IRQ=1 and BUSY=0, then go to IDLE.
- Handshake rules:
  - At most one of MEM_RD, MEM_WR, REG_RD, REG_WR is high in any cycle.
  - The request is never withdrawn before RDY.
  - RDY while no request is pending is ignored.
  - A RDY that arrives in the same cycle a request is first raised completes that access (minimum 1 cycle per access).
- Address wrap-around: addresses wrap modulo 2^MEM_AW and 2^REG_AW without error.
- Latency:
  - Zero-wait ports: 2 cycles per word, or 1 per word with DGATE.
  - From DEXE_SET to DONE_IRQ = 1 + 2·N + 1 cycles; with DGATE, 1 + N + 1 cycles.
- Ports not in use for the current direction hold address/data at their last value with requests low.

Test Plan:
- Mem→reg, zero-wait: DMEA=19'h00100, DRGA=11'h200, DTLG=3, DDIR=0, memory words 1111/2222/3333. Expect REG_WR at addresses 200/201/202 with data 1111/2222/3333, BUSY high for 7 cycles, DONE_IRQ on cycle 8.
- Reg→mem with RDY delayed 3 cycles per access, DTLG=2. Expect requests held stable throughout, MEM_WR addresses DMEA and DMEA+1 carrying REG_DI values, exactly 2 reads and 2 writes, then one DONE_IRQ pulse.
- DGATE=1, DDIR=1, DTLG=4, DMEA=19'h7FFFE. Expect no REG_RD, MEM_WR to 7FFFE, 7FFFF, 00000, 00001 with data 0000 (address wrap), DONE_IRQ at cycle 6.
- DTLG=0, DEXE_SET pulse. Expect no port requests, BUSY high for 1 cycle, DONE_IRQ on cycle 2.
- DEXE_SET re-pulsed and DTLG changed to 5 during a DTLG=2 transfer. Expect the transfer to complete with exactly 2 words and a single DONE_IRQ.
- RST_N low while MEM_RD is pending in word 2. Expect all requests, BUSY and DONE_IRQ at 0 asynchronously. After release, a new DEXE_SET restarts from the freshly latched DMEA/DRGA.
